ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_pkg.sv | 10 +
 rtl/ex_mem_stage_if.sv | 25 ++
 rtl/ex_mul_seq.sv | 51 +++++
 rtl/ex_mem_stage.sv | 85 ++++++++
 tb/tb_ex_mem_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: opcode encodings, multiplier FSM states and default datapath width
// shared by the EX stage files.
package ex_pkg;
    localparam int DW_DEF = 8;
    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_MUL, OP_LD, OP_ST
    } op_t;
    typedef enum logic {S_IDLE, S_MUL} mul_state_t;
endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: ID/EX inputs, forward sources and EX/MEM register outputs.
interface ex_mem_stage_if #(parameter int DW = 8);
    logic          flush;
    logic [3:0]    opcode_in;
    logic [DW-1:0] A_in, B_in;
    logic [2:0]    rs_in, rt_in, rd_in;
    logic          mem_fwd_we, wb_fwd_we;
    logic [2:0]    mem_fwd_rd, wb_fwd_rd;
    logic [DW-1:0] mem_fwd_data, wb_fwd_data;
    logic          ex_busy;
    logic [3:0]    opcode_out;
    logic [DW-1:0] result_out, store_data_out;
    logic [2:0]    rd_out;
    logic          reg_we_out;
    modport master (
        output flush, opcode_in, A_in, B_in, rs_in, rt_in, rd_in,
               mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
        input  ex_busy, opcode_out, result_out, store_data_out, rd_out, reg_we_out
    );
    modport slave (
        input  flush, opcode_in, A_in, B_in, rs_in, rt_in, rd_in,
               mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
        output ex_busy, opcode_out, result_out, store_data_out, rd_out, reg_we_out
    );
endinterface

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: 8-iteration shift-add multiplier; done is combinational on the
// last iteration so the final partial product is folded into product.
module ex_mul_seq
    import ex_pkg::*;
#(parameter int DW = DW_DEF)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          abort,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product
);
    mul_state_t    state;
    logic [2:0]    cnt;
    logic [DW-1:0] acc, ma, mb;

    assign product = acc + (mb[0] ? ma : '0);
    assign done    = state == S_MUL && cnt == 3'd7;
    assign busy    = (state == S_IDLE && start) || (state == S_MUL && cnt != 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            ma    <= '0;
            mb    <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                ma    <= a;
                mb    <= b;
                acc   <= '0;
                cnt   <= '0;
                state <= S_MUL;
            end
        end else begin
            acc   <= product;
            ma    <= ma << 1;
            mb    <= mb >> 1;
            cnt   <= cnt + 3'd1;
            state <= done ? S_IDLE : S_MUL;
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage with two-level operand forwarding and EX/MEM register.
// Define EX_MUL_EN to build the sequential multiplier; otherwise opcode 8 is a NOP.
module ex_mem_stage
    import ex_pkg::*;
#(parameter int DW = DW_DEF)
(
    input logic clk,
    input logic rst,
    ex_mem_stage_if.slave bus
);
    logic [DW-1:0] fa, fb, alu, st, product;
    logic [3:0]    op;
    logic          we, busy, mul_done;

    // MEM result is newer than WB, so it wins; r0 is never forwarded
    assign fa = (bus.mem_fwd_we && bus.mem_fwd_rd == bus.rs_in && bus.rs_in != 3'd0) ? bus.mem_fwd_data :
                (bus.wb_fwd_we && bus.wb_fwd_rd == bus.rs_in && bus.rs_in != 3'd0) ? bus.wb_fwd_data : bus.A_in;
    assign fb = (bus.mem_fwd_we && bus.mem_fwd_rd == bus.rt_in && bus.rt_in != 3'd0) ? bus.mem_fwd_data :
                (bus.wb_fwd_we && bus.wb_fwd_rd == bus.rt_in && bus.rt_in != 3'd0) ? bus.wb_fwd_data : bus.B_in;

    always_comb begin
        alu = '0;
        st  = '0;
        case (bus.opcode_in)
            OP_ADD, OP_LD: alu = fa + fb;
            OP_SUB:        alu = fa - fb;
            OP_AND:        alu = fa & fb;
            OP_OR:         alu = fa | fb;
            OP_XOR:        alu = fa ^ fb;
            OP_SLL:        alu = fa << fb[2:0];
            OP_SRL:        alu = fa >> fb[2:0];
            OP_ST: begin
                alu = fa + fb;
                st  = fb;
            end
            default:       alu = '0;
        endcase
    end

    // MUL only reaches EX/MEM through the multiplier's done path
    assign op = (bus.opcode_in > 4'd10 || bus.opcode_in == OP_MUL) ? OP_NOP : bus.opcode_in;
    assign we = op != OP_NOP && op != OP_ST && bus.rd_in != 3'd0;

`ifdef EX_MUL_EN
    ex_mul_seq #(.DW(DW)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .abort   (bus.flush),
        .start   (bus.opcode_in == OP_MUL),
        .a       (fa),
        .b       (fb),
        .busy    (busy),
        .done    (mul_done),
        .product (product)
    );
`else
    assign busy     = 1'b0;
    assign mul_done = 1'b0;
    assign product  = '0;
`endif

    assign bus.ex_busy = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.opcode_out     <= '0;
            bus.result_out     <= '0;
            bus.store_data_out <= '0;
            bus.rd_out         <= '0;
            bus.reg_we_out     <= 1'b0;
        end else if (bus.flush || busy) begin
            bus.opcode_out     <= '0;
            bus.result_out     <= '0;
            bus.store_data_out <= '0;
            bus.rd_out         <= '0;
            bus.reg_we_out     <= 1'b0;
        end else begin
            bus.opcode_out     <= mul_done ? OP_MUL : op;
            bus.result_out     <= mul_done ? product : alu;
            bus.store_data_out <= mul_done ? '0 : st;
            bus.rd_out         <= bus.rd_in;
            bus.reg_we_out     <= mul_done ? bus.rd_in != 3'd0 : we;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors for ex_mem_stage; MUL checks follow EX_MUL_EN.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    ex_mem_stage_if #(.DW(8)) bus ();
    ex_mem_stage #(.DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        bus.opcode_in    = op;
        bus.A_in         = a;
        bus.B_in         = b;
        bus.rs_in        = rs;
        bus.rt_in        = rt;
        bus.rd_in        = rd;
        bus.mem_fwd_we   = 1'b0;
        bus.mem_fwd_rd   = 3'd0;
        bus.mem_fwd_data = 8'h00;
        bus.wb_fwd_we    = 1'b0;
        bus.wb_fwd_rd    = 3'd0;
        bus.wb_fwd_data  = 8'h00;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] rd,
                           input logic [7:0] exp_res, input logic exp_we);
        drive(op, a, b, 3'd0, 3'd0, rd);
        step();
        check({tag, "_res"}, bus.result_out, exp_res);
        check({tag, "_we"}, bus.reg_we_out, exp_we);
    endtask

    initial begin
        int bad;
        bus.flush = 1'b0;
        drive(4'd0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
        step();
        step();
        check("rst_res", bus.result_out, 0);
        check("rst_we", bus.reg_we_out, 0);
        check("rst_op", bus.opcode_out, 0);
        check("rst_busy", bus.ex_busy, 0);
        rst = 1'b0;

        drive(4'd1, 8'h7F, 8'h01, 3'd0, 3'd0, 3'd3);
        step();
        check("add_res", bus.result_out, 8'h80);
        check("add_we", bus.reg_we_out, 1);
        check("add_rd", bus.rd_out, 3);
        check("add_op", bus.opcode_out, 1);

        alu_vec("sub", 4'd2, 8'h00, 8'h01, 3'd1, 8'hFF, 1'b1);
        alu_vec("and", 4'd3, 8'hF0, 8'h3C, 3'd2, 8'h30, 1'b1);
        alu_vec("or",  4'd4, 8'h0F, 8'h30, 3'd2, 8'h3F, 1'b1);
        alu_vec("xor", 4'd5, 8'hFF, 8'h0F, 3'd2, 8'hF0, 1'b1);
        alu_vec("sll", 4'd6, 8'h81, 8'h09, 3'd2, 8'h02, 1'b1);
        alu_vec("srl", 4'd7, 8'h80, 8'h0B, 3'd2, 8'h10, 1'b1);
        alu_vec("ld",  4'd9, 8'h10, 8'h05, 3'd4, 8'h15, 1'b1);
        alu_vec("rd0", 4'd1, 8'h01, 8'h01, 3'd0, 8'h02, 1'b0);
        alu_vec("op12", 4'd12, 8'h05, 8'h03, 3'd2, 8'h00, 1'b0);
        check("op12_op", bus.opcode_out, 0);
        alu_vec("st",  4'd10, 8'h10, 8'h05, 3'd6, 8'h15, 1'b0);
        check("st_data", bus.store_data_out, 8'h05);

        drive(4'd4, 8'h11, 8'h00, 3'd2, 3'd0, 3'd1);
        bus.mem_fwd_we = 1'b1; bus.mem_fwd_rd = 3'd2; bus.mem_fwd_data = 8'h55;
        bus.wb_fwd_we = 1'b1; bus.wb_fwd_rd = 3'd2; bus.wb_fwd_data = 8'hAA;
        step();
        check("fwd_mem_prio", bus.result_out, 8'h55);
        bus.mem_fwd_we = 1'b0;
        step();
        check("fwd_wb", bus.result_out, 8'hAA);

        drive(4'd2, 8'h30, 8'h99, 3'd0, 3'd4, 3'd1);
        bus.mem_fwd_we = 1'b1; bus.mem_fwd_rd = 3'd3; bus.mem_fwd_data = 8'h77;
        bus.wb_fwd_we = 1'b1; bus.wb_fwd_rd = 3'd4; bus.wb_fwd_data = 8'h10;
        step();
        check("fwd_b_wb", bus.result_out, 8'h20);

        drive(4'd1, 8'h01, 8'h01, 3'd0, 3'd0, 3'd1);
        bus.mem_fwd_we = 1'b1; bus.mem_fwd_rd = 3'd0; bus.mem_fwd_data = 8'hFF;
        step();
        check("no_fwd_r0", bus.result_out, 8'h02);

        drive(4'd1, 8'h05, 8'h05, 3'd0, 3'd0, 3'd2);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_add_res", bus.result_out, 0);
        check("flush_add_we", bus.reg_we_out, 0);

`ifdef EX_MUL_EN
        drive(4'd8, 8'h0C, 8'h0B, 3'd0, 3'd0, 3'd5);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.ex_busy !== 1'b1) bad++;
            step();
            if (bus.reg_we_out !== 1'b0 || bus.result_out !== 8'h00) bad++;
        end
        check("mul_busy_bubbles", bad, 0);
        check("mul_last_busy", bus.ex_busy, 0);
        step();
        check("mul_res", bus.result_out, 8'h84);
        check("mul_we", bus.reg_we_out, 1);
        check("mul_rd", bus.rd_out, 5);
        check("mul_op", bus.opcode_out, 8);
        drive(4'd0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
        step();

        drive(4'd8, 8'h0C, 8'h0B, 3'd0, 3'd0, 3'd5);
        for (int i = 0; i < 5; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(4'd0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
        check("flush_mul_busy", bus.ex_busy, 0);
        check("flush_mul_we", bus.reg_we_out, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.reg_we_out !== 1'b0 || bus.result_out === 8'h84 || bus.ex_busy !== 1'b0) bad++;
        end
        check("flush_mul_no_result", bad, 0);

        drive(4'd8, 8'h0C, 8'h0B, 3'd0, 3'd0, 3'd5);
        for (int i = 0; i < 3; i++) step();
        drive(4'd0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_mul_busy", bus.ex_busy, 0);
        check("rst_mid_mul_we", bus.reg_we_out, 0);
        check("rst_mid_mul_res", bus.result_out, 0);
        step();
        rst = 1'b0;
`else
        drive(4'd8, 8'h0C, 8'h0B, 3'd0, 3'd0, 3'd5);
        check("mul_nop_busy", bus.ex_busy, 0);
        step();
        check("mul_nop_res", bus.result_out, 0);
        check("mul_nop_we", bus.reg_we_out, 0);
        check("mul_nop_op", bus.opcode_out, 0);

        drive(4'd1, 8'h40, 8'h02, 3'd0, 3'd0, 3'd6);
        step();
        check("pre_rst_res", bus.result_out, 8'h42);
        rst = 1'b1;
        #1;
        check("async_rst_res", bus.result_out, 0);
        check("async_rst_we", bus.reg_we_out, 0);
        check("async_rst_rd", bus.rd_out, 0);
        step();
        rst = 1'b0;
`endif

        drive(4'd1, 8'h7F, 8'h01, 3'd0, 3'd0, 3'd3);
        step();
        check("post_rst_add_res", bus.result_out, 8'h80);
        check("post_rst_add_we", bus.reg_we_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
